sd_spi_rx_framer: RTL and testbench
===================================

Name: sd_spi_rx_framer

Overview:
- Receive-side framer for the SD-card SPI link; sits directly downstream of the MISO sampling point.
- Shifts sampled MISO bits MSB-first into bytes and hunts for the R1 response or the 0xFE data-start token.
- Streams the data-block payload to the Sobel line buffer over valid/ready and captures the trailing CRC16.
- Holds SCLK off via back-pressure so that no payload byte is ever dropped.

Parameters:
- BLOCK_BYTES, 512, payload bytes per data block (>=1).
- NCR_MAX, 8, max bytes of 0xFF before R1 timeout.
- TOKEN_TIMEOUT, 4096, max bytes of 0xFF before data-token timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_strobe  in  1  one-cycle pulse; miso valid this cycle (SCLK rising edge).
- miso  in  1  serial data from card.
- start_resp  in  1  pulse: begin R1 hunt.
- start_block  in  1  pulse: begin data-token hunt and block receive.
- abort  in  1  pulse: return to IDLE.
- byte_ready  in  1  consumer accepts byte_data.
- byte_data  out  8  payload byte.
- byte_valid  out  1  byte_data valid.
- resp_r1  out  8  captured R1.
- resp_done  out  1  one-cycle pulse, R1 captured.
- block_done  out  1  one-cycle pulse, block plus CRC received.
- crc_out  out  16  received CRC16, MSB byte first.
- err  out  1  sticky until next start: timeout, bad token or overrun.
- err_code  out  2  0 timeout, 1 error token, 2 overrun.
- sclk_hold  out  1  clock generator must issue no strobes while high.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, shift register 8'hFF, counters 0.
- Shift register: shifts only on sample_strobe, new bit enters LSB (MSB-first). Bit counter 0..7; byte completes on the strobe that makes the count wrap 7->0.
- States: IDLE, WAIT_R1, WAIT_TOKEN, DATA, CRC, DONE.
- IDLE: start_resp -> WAIT_R1; start_block -> WAIT_TOKEN. Both starts asserted: start_resp wins. Any start clears err, err_code, byte counter and bit counter, and reloads the shift register to 8'hFF.
- WAIT_R1: bit-aligned hunt. The first strobe with miso=0 sets the bit counter to 1 (start bit = R1 MSB). After 7 more strobes: resp_r1 <= byte, resp_done pulses the next cycle, state -> IDLE. If NCR_MAX*8 strobes pass with no 0 bit: err=1, err_code=0, state -> IDLE.
- WAIT_TOKEN: byte-aligned.
  - Byte 0xFF: increment timeout counter.
  - Byte 0xFE: -> DATA.
  - Upper nibble 0000: err_code=1, -> IDLE.
  - Any other byte: err_code=1, -> IDLE.
  - Counter reaching TOKEN_TIMEOUT: err_code=0, -> IDLE.
- DATA: each completed byte loads byte_data and sets byte_valid the cycle after the completing strobe (latency 1). byte_valid clears on a cycle with byte_valid & byte_ready. After BLOCK_BYTES bytes -> CRC.
- sclk_hold = byte_valid & ~byte_ready & (state==DATA).
- Overrun: a byte completes while byte_valid is still high and not being accepted that cycle -> err_code=2, byte_valid cleared, -> IDLE. A byte completing in the same cycle as an accept is legal.
- CRC: two bytes; first -> crc_out[15:8], second -> crc_out[7:0]; not presented on byte_data. Then -> DONE.
- DONE: block_done pulses one cycle, -> IDLE. crc_out holds until the next start_block.
- abort in any state: next cycle IDLE, byte_valid=0, sclk_hold=0; err, crc_out and resp_r1 unchanged. abort beats a start in the same cycle.
- Strobes in IDLE are ignored.
- Byte counter width: $clog2(BLOCK_BYTES+1). Timeout counter width: $clog2(TOKEN_TIMEOUT+1); saturating.
- Async rst mid-block: immediate IDLE, all outputs to reset values.

Decomposition:
- Package sd_spi_pkg holds:
  - rx_state_t enum (IDLE, WAIT_R1, WAIT_TOKEN, DATA, CRC, DONE).
  - Constants DATA_START_TOKEN=8'hFE, IDLE_BYTE=8'hFF.
  - Error-code localparams ERR_TIMEOUT=0, ERR_TOKEN=1, ERR_OVERRUN=2.
- One sub-module: sd_rx_byte_shifter (8-bit MSB-first shifter with bit counter, bit-align load and byte_done pulse). The FSM and counters stay in the top.

Test Plan:
- R1 hunt: start_resp, 11 strobes of 1, then bits 0000_0001 -> resp_r1=8'h01, resp_done one pulse, busy low next cycle, err=0.
- R1 timeout: start_resp, 64 strobes of miso=1 -> err=1, err_code=0, no resp_done.
- Block read, BLOCK_BYTES=4: start_block, 0xFF, 0xFE, A5 3C 00 FF, CRC 12 34, byte_ready=1 -> byte_data sequence A5,3C,00,FF; crc_out=16'h1234; block_done one pulse.
- Back-pressure: same block with byte_ready=0 for 20 cycles after the first byte -> sclk_hold high exactly while byte_valid&~byte_ready; no data loss. Strobe forced during hold -> err_code=2.
- Error token: start_block, byte 0x08 -> err=1, err_code=1, state IDLE, no byte_valid.
- Abort/reset: rst high for 1 cycle mid-DATA after 2 bytes -> all outputs 0 immediately. Separately, abort together with start_block -> stays IDLE.

Source files
------------

// File: rtl/sd_spi_rx_framer_pkg.sv
// Shared types and constants for the SD-card SPI receive framer.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_R1,
    WAIT_TOKEN,
    DATA,
    CRC,
    DONE
  } rx_state_t;

  localparam logic [7:0] DATA_START_TOKEN = 8'hFE;
  localparam logic [7:0] IDLE_BYTE        = 8'hFF;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_TOKEN   = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sd_rx_byte_shifter.sv
// MSB-first MISO deserialiser; in align mode the bit counter holds at 0 until
// the first 0 bit, which becomes the MSB of the byte.
module sd_rx_byte_shifter
  import sd_spi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       reload_i,
  input  logic       enable_i,
  input  logic       align_i,
  input  logic       strobe_i,
  input  logic       miso_i,
  output logic [7:0] byte_o,
  output logic       byte_done_o,
  output logic       idle_bit_o
);

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       shift;

  assign shift       = strobe_i & enable_i;
  assign byte_o      = {shreg_q[6:0], miso_i};
  assign byte_done_o = shift & (bit_cnt_q == 3'd7);
  assign idle_bit_o  = shift & align_i & (bit_cnt_q == 3'd0) & miso_i;

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (reload_i) begin
      shreg_d   = IDLE_BYTE;
      bit_cnt_d = 3'd0;
    end else if (shift) begin
      shreg_d = byte_o;
      if (!idle_bit_o) bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q   <= IDLE_BYTE;
      bit_cnt_q <= 3'd0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/sd_spi_rx_framer.sv
// SD SPI receive framer: hunts R1 or the data-start token, streams the payload
// over valid/ready and captures CRC16; holds SCLK while a byte waits unaccepted.
module sd_spi_rx_framer
  import sd_spi_pkg::*;
#(
  parameter int BLOCK_BYTES   = 512,
  parameter int NCR_MAX       = 8,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_strobe,
  input  logic        miso,
  input  logic        start_resp,
  input  logic        start_block,
  input  logic        abort,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic [7:0]  resp_r1,
  output logic        resp_done,
  output logic        block_done,
  output logic [15:0] crc_out,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        sclk_hold,
  output logic        busy
);

  localparam int BC_W = $clog2(BLOCK_BYTES + 1);
  // Shared between the R1 bit hunt and the token byte hunt, so sized for both.
  localparam int TO_W = max_int($clog2(TOKEN_TIMEOUT + 1), $clog2(NCR_MAX * 8 + 1));
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BLOCK_BYTES - 1);
  localparam logic [TO_W-1:0] TOK_LAST  = TO_W'(TOKEN_TIMEOUT - 1);
  localparam logic [TO_W-1:0] R1_LAST   = TO_W'(NCR_MAX * 8 - 1);

  rx_state_t       state_q, state_d;
  logic [7:0]      byte_data_q, byte_data_d;
  logic            byte_valid_q, byte_valid_d;
  logic [7:0]      resp_r1_q, resp_r1_d;
  logic            resp_done_q, resp_done_d;
  logic [15:0]     crc_q, crc_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic [7:0]      rx_byte;
  logic            byte_done, idle_bit, shift_en, start_go;
  logic            overrun, tok_timeout, r1_timeout;
  logic [TO_W-1:0] to_inc;

  assign start_go    = (state_q == IDLE) & ~abort & (start_resp | start_block);
  assign shift_en    = (state_q == WAIT_R1) | (state_q == WAIT_TOKEN) |
                       (state_q == DATA) | (state_q == CRC);
  assign overrun     = byte_valid_q & ~byte_ready;
  assign tok_timeout = (to_cnt_q >= TOK_LAST);
  assign r1_timeout  = (to_cnt_q >= R1_LAST);
  assign to_inc      = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;

  sd_rx_byte_shifter u_shifter (
    .clk_i       (clk),
    .rst_i       (rst),
    .reload_i    (start_go),
    .enable_i    (shift_en),
    .align_i     (state_q == WAIT_R1),
    .strobe_i    (sample_strobe),
    .miso_i      (miso),
    .byte_o      (rx_byte),
    .byte_done_o (byte_done),
    .idle_bit_o  (idle_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start_go) state_d = start_resp ? WAIT_R1 : WAIT_TOKEN;
      WAIT_R1:    if (byte_done || (idle_bit && r1_timeout)) state_d = IDLE;
      WAIT_TOKEN: begin
        if (byte_done) begin
          if (rx_byte == DATA_START_TOKEN)                  state_d = DATA;
          else if (rx_byte != IDLE_BYTE || tok_timeout)     state_d = IDLE;
        end
      end
      DATA: begin
        if (byte_done) begin
          if (overrun)                       state_d = IDLE;
          else if (byte_cnt_q == LAST_BYTE)  state_d = CRC;
        end
      end
      CRC:     if (byte_done && byte_cnt_q != '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    busy       = (state_q != IDLE);
    block_done = (state_q == DONE);
    sclk_hold  = byte_valid_q & ~byte_ready & (state_q == DATA);
  end

  always_comb begin
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q;
    resp_r1_d    = resp_r1_q;
    resp_done_d  = 1'b0;
    crc_d        = crc_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    byte_cnt_d   = byte_cnt_q;
    to_cnt_d     = to_cnt_q;
    if (byte_valid_q && byte_ready) byte_valid_d = 1'b0;
    if (abort) begin
      byte_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_go) begin
            err_d      = 1'b0;
            err_code_d = ERR_TIMEOUT;
            byte_cnt_d = '0;
            to_cnt_d   = '0;
            if (!start_resp) crc_d = '0;
          end
        end
        WAIT_R1: begin
          if (byte_done) begin
            resp_r1_d   = rx_byte;
            resp_done_d = 1'b1;
          end else if (idle_bit) begin
            if (r1_timeout) begin
              err_d      = 1'b1;
              err_code_d = ERR_TIMEOUT;
            end else begin
              to_cnt_d = to_inc;
            end
          end
        end
        WAIT_TOKEN: begin
          if (byte_done && rx_byte != DATA_START_TOKEN) begin
            if (rx_byte != IDLE_BYTE) begin
              err_d      = 1'b1;
              err_code_d = ERR_TOKEN;
            end else if (tok_timeout) begin
              err_d      = 1'b1;
              err_code_d = ERR_TIMEOUT;
            end else begin
              to_cnt_d = to_inc;
            end
          end
        end
        DATA: begin
          if (byte_done) begin
            if (overrun) begin
              err_d        = 1'b1;
              err_code_d   = ERR_OVERRUN;
              byte_valid_d = 1'b0;
            end else begin
              byte_data_d  = rx_byte;
              byte_valid_d = 1'b1;
              byte_cnt_d   = (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + 1'b1;
            end
          end
        end
        CRC: begin
          if (byte_done) begin
            if (byte_cnt_q == '0) begin
              crc_d[15:8] = rx_byte;
              byte_cnt_d  = BC_W'(1);
            end else begin
              crc_d[7:0] = rx_byte;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      resp_r1_q    <= '0;
      resp_done_q  <= 1'b0;
      crc_q        <= '0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_TIMEOUT;
      byte_cnt_q   <= '0;
      to_cnt_q     <= '0;
    end else begin
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      resp_r1_q    <= resp_r1_d;
      resp_done_q  <= resp_done_d;
      crc_q        <= crc_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      byte_cnt_q   <= byte_cnt_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign resp_r1    = resp_r1_q;
  assign resp_done  = resp_done_q;
  assign crc_out    = crc_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_sd_spi_rx_framer.sv
// Scoreboard bench for sd_spi_rx_framer: stimulus pushes expected bytes, R1 and
// CRC values; a negedge monitor pops and compares on every DUT output event.
module tb_sd_spi_rx_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_strobe = 1'b0;
  logic        miso = 1'b1;
  logic        start_resp = 1'b0;
  logic        start_block = 1'b0;
  logic        abort = 1'b0;
  logic        byte_ready = 1'b1;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [7:0]  resp_r1;
  logic        resp_done;
  logic        block_done;
  logic [15:0] crc_out;
  logic        err;
  logic [1:0]  err_code;
  logic        sclk_hold;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0]  exp_bytes[$];
  logic [7:0]  exp_r1[$];
  logic [15:0] exp_crc[$];

  sd_spi_rx_framer #(.BLOCK_BYTES(4), .NCR_MAX(8), .TOKEN_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .sample_strobe(sample_strobe), .miso(miso),
    .start_resp(start_resp), .start_block(start_block), .abort(abort),
    .byte_ready(byte_ready), .byte_data(byte_data), .byte_valid(byte_valid),
    .resp_r1(resp_r1), .resp_done(resp_done), .block_done(block_done),
    .crc_out(crc_out), .err(err), .err_code(err_code), .sclk_hold(sclk_hold),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid && byte_ready) begin
        if (exp_bytes.size() == 0) chk("byte_extra", 32'(byte_valid), 32'd0);
        else chk("byte_data", 32'(byte_data), 32'(exp_bytes.pop_front()));
      end
      if (resp_done) begin
        if (exp_r1.size() == 0) chk("resp_done_extra", 32'(resp_done), 32'd0);
        else chk("resp_r1", 32'(resp_r1), 32'(exp_r1.pop_front()));
      end
      if (block_done) begin
        if (exp_crc.size() == 0) chk("block_done_extra", 32'(block_done), 32'd0);
        else chk("crc_out", 32'(crc_out), 32'(exp_crc.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit force_it);
    int w;
    w = 0;
    while (sclk_hold && !force_it && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) chk("hold_wait_expired", 32'(sclk_hold), 32'd0);
    miso = b;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    miso = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] v, input bit force_it);
    for (int i = 7; i >= 0; i--) send_bit(v[i], force_it);
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 1'b0);
  endtask

  task automatic pulse(input logic r, input logic b, input logic a);
    start_resp = r;
    start_block = b;
    abort = a;
    tick();
    start_resp = 1'b0;
    start_block = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] blk[6];
    int hold_cnt;
    blk[0] = 8'hA5; blk[1] = 8'h3C; blk[2] = 8'h00; blk[3] = 8'hFF;
    blk[4] = 8'h12; blk[5] = 8'h34;

    // reset values
    tick(); tick();
    chk("reset_flags", 32'({byte_valid, resp_done, block_done, err, err_code, sclk_hold, busy}), 32'd0);
    chk("reset_data", 32'({byte_data, resp_r1, crc_out}), 32'd0);
    rst = 1'b0;
    tick();

    // R1 hunt with 11 idle bits then 0x01
    pulse(1'b1, 1'b0, 1'b0);
    exp_r1.push_back(8'h01);
    send_ones(11);
    send_byte(8'h01, 1'b0);
    chk("r1_busy_after", 32'(busy), 32'd0);
    chk("r1_err", 32'(err), 32'd0);

    // R1 timeout: 63 idle bits still hunting, the 64th times out
    pulse(1'b1, 1'b0, 1'b0);
    send_ones(63);
    chk("r1_to_busy_63", 32'({busy, err}), 32'b10);
    send_ones(1);
    chk("r1_to_err", 32'({busy, err, err_code}), 32'b0100);

    // block read with ready held high
    pulse(1'b0, 1'b1, 1'b0);
    chk("start_clears_err", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) exp_bytes.push_back(blk[i]);
    exp_crc.push_back(16'h1234);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFE, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(blk[i], 1'b0);
    chk("blk_crc_hold", 32'(crc_out), 32'h1234);
    chk("blk_idle", 32'({busy, err}), 32'd0);

    // back-pressure: first byte stalls for 20 cycles, SCLK held meanwhile
    pulse(1'b0, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFE, 1'b0);
    byte_ready = 1'b0;
    exp_bytes.push_back(blk[0]);
    send_byte(blk[0], 1'b0);
    hold_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (sclk_hold) hold_cnt++;
      tick();
    end
    chk("bp_hold_cycles", 32'(hold_cnt), 32'd20);
    chk("bp_byte_held", 32'({byte_valid, byte_data}), 32'h1A5);
    byte_ready = 1'b1;
    tick();
    chk("bp_hold_release", 32'({sclk_hold, byte_valid}), 32'd0);
    for (int i = 1; i < 4; i++) exp_bytes.push_back(blk[i]);
    exp_crc.push_back(16'h1234);
    for (int i = 1; i < 6; i++) send_byte(blk[i], 1'b0);
    chk("bp_err", 32'(err), 32'd0);

    // overrun: strobes forced through the hold
    pulse(1'b0, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFE, 1'b0);
    byte_ready = 1'b0;
    send_byte(blk[0], 1'b0);
    chk("ovr_hold", 32'(sclk_hold), 32'd1);
    send_byte(blk[1], 1'b1);
    chk("ovr_err", 32'({busy, byte_valid, err, err_code}), 32'b00110);
    byte_ready = 1'b1;

    // error tokens
    pulse(1'b0, 1'b1, 1'b0);
    send_byte(8'h08, 1'b0);
    chk("tok08_err", 32'({busy, byte_valid, err, err_code}), 32'b00101);
    pulse(1'b0, 1'b1, 1'b0);
    send_byte(8'h5A, 1'b0);
    chk("tok5A_err", 32'({busy, byte_valid, err, err_code}), 32'b00101);

    // token timeout at 16 idle bytes
    pulse(1'b0, 1'b1, 1'b0);
    chk("tok_start_clear", 32'({err, err_code}), 32'd0);
    for (int i = 0; i < 15; i++) send_byte(8'hFF, 1'b0);
    chk("tok_to_15", 32'({busy, err}), 32'b10);
    send_byte(8'hFF, 1'b0);
    chk("tok_to_16", 32'({busy, err, err_code}), 32'b0100);

    // abort beats start; err left as it was
    pulse(1'b0, 1'b1, 1'b1);
    chk("abort_start", 32'({busy, err, err_code}), 32'b0100);
    tick();
    chk("abort_start_idle", 32'(busy), 32'd0);

    // async reset mid-DATA after two bytes
    pulse(1'b0, 1'b1, 1'b0);
    exp_bytes.push_back(blk[0]);
    exp_bytes.push_back(blk[1]);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(blk[0], 1'b0);
    send_byte(blk[1], 1'b0);
    chk("pre_rst_busy", 32'({busy, byte_data}), 32'h13C);
    rst = 1'b1;
    #1;
    chk("rst_async_flags", 32'({byte_valid, resp_done, block_done, err, err_code, sclk_hold, busy}), 32'd0);
    chk("rst_async_data", 32'({byte_data, resp_r1, crc_out}), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // abort while a byte is stalled
    pulse(1'b0, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFE, 1'b0);
    byte_ready = 1'b0;
    send_byte(blk[2], 1'b0);
    chk("abort_pre_hold", 32'(sclk_hold), 32'd1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("abort_mid", 32'({busy, byte_valid, sclk_hold, err}), 32'd0);
    byte_ready = 1'b1;
    tick();

    chk("left_bytes", 32'(exp_bytes.size()), 32'd0);
    chk("left_r1", 32'(exp_r1.size()), 32'd0);
    chk("left_crc", 32'(exp_crc.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
